// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes,
// opcode constants and the encodings of the datapath mux selects and aluop.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_mc_outdec.sv
// State -> control-word lookup for the multi-cycle controller (Moore outputs).
// Strobes here are raw: the top adds the FETCH mem_ready term and reset mask.
// Optional macro MIPS_MC_BNE_EN enables the bne strobe in BNEEX.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  logic [3:0] state_i,
  output logic       pcwrite_o,
  output logic       branch_o,
  output logic       bne_o,
  output logic       memwrite_o,
  output logic       iord_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic [1:0] aluop_o
);

  // Control word per state; everything not named for a state stays 0.
  always_comb begin
    pcwrite_o  = 1'b0;
    branch_o   = 1'b0;
    bne_o      = 1'b0;
    memwrite_o = 1'b0;
    iord_o     = 1'b0;
    regwrite_o = 1'b0;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = ALUSRCB_REGB;
    pcsrc_o    = PCSRC_ALU;
    aluop_o    = ALUOP_ADD;
    case (state_i)
      S_FETCH: begin
        alusrcb_o = ALUSRCB_FOUR;
      end
      S_DECODE: begin
        alusrcb_o = ALUSRCB_IMMSH;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        iord_o = 1'b1;
      end
      S_MEMWB: begin
        memtoreg_o = 1'b1;
        regwrite_o = 1'b1;
      end
      S_MEMWR: begin
        iord_o     = 1'b1;
        memwrite_o = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst_o   = 1'b1;
        regwrite_o = 1'b1;
      end
      S_BEQEX: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        branch_o  = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_o = 1'b1;
      end
      S_JEX: begin
        pcsrc_o   = PCSRC_JUMP;
        pcwrite_o = 1'b1;
      end
`ifdef MIPS_MC_BNE_EN
      S_BNEEX: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        bne_o     = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared memory with a mem_ready handshake.
// Handshake: an access in FETCH, MEMRD or MEMWR is requested for as long as
// the FSM sits in that state; the cycle where mem_ready=1 completes it and
// the FSM advances on the following edge. mem_ready is ignored elsewhere.
// Optional macro MIPS_MC_BNE_EN adds bne decoding and the BNEEX state.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               bne,
  output logic               irwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t state_q, state_d;
  logic   illegal_d;
  logic   is_fetch;
  logic   dec_pcwrite, dec_branch, dec_bne, dec_memwrite, dec_regwrite;

  // State register; reset returns to FETCH and abandons any instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic, including opcode dispatch and illegal-op detection.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mips_mc_outdec u_outdec (
    .state_i    (state_q),
    .pcwrite_o  (dec_pcwrite),
    .branch_o   (dec_branch),
    .bne_o      (dec_bne),
    .memwrite_o (dec_memwrite),
    .iord_o     (iord),
    .regwrite_o (dec_regwrite),
    .regdst_o   (regdst),
    .memtoreg_o (memtoreg),
    .alusrca_o  (alusrca),
    .alusrcb_o  (alusrcb),
    .pcsrc_o    (pcsrc),
    .aluop_o    (aluop)
  );

  // Strobes: FETCH loads PC and IR on the completing cycle; reset masks all.
  always_comb begin
    is_fetch   = (state_q == S_FETCH);
    pcwrite    = rst_n & (dec_pcwrite | (is_fetch & mem_ready));
    irwrite    = rst_n & is_fetch & mem_ready;
    branch     = rst_n & dec_branch;
    bne        = rst_n & dec_bne;
    memwrite   = rst_n & dec_memwrite;
    regwrite   = rst_n & dec_regwrite;
    illegal_op = rst_n & illegal_d;
    state_o    = STATE_W'(state_q);
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl. Inputs change and outputs are sampled
// just after each falling edge; the DUT registers on the rising edge.
module tb_mips_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, bne, irwrite, memwrite, iord, regwrite;
  logic       regdst, memtoreg, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  mips_mc_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .bne        (bne),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if (state_o !== 4'd0) begin n_err++; $display("FAIL reset_state cyc%0d: got %0d exp 0", i, state_o); end
      n_vec++;
      if ({pcwrite, branch, bne, irwrite, memwrite, regwrite, illegal_op} !== 7'b0) begin
        n_err++; $display("FAIL reset_strobes cyc%0d: got %b exp 0000000", i,
          {pcwrite, branch, bne, irwrite, memwrite, regwrite, illegal_op});
      end
    end
    rst_n = 1'b1; #1;
    n_vec++;
    if (state_o !== 4'd0) begin n_err++; $display("FAIL release_state: got %0d exp 0", state_o); end
    n_vec++;
    if ({pcwrite, irwrite} !== 2'b11) begin n_err++; $display("FAIL release_fetch_we: got %b exp 11", {pcwrite, irwrite}); end
    n_vec++;
    if ({iord, alusrca, alusrcb, aluop, pcsrc} !== 8'b0_0_01_00_00) begin
      n_err++; $display("FAIL fetch_muxes: got %b exp 00010000", {iord, alusrca, alusrcb, aluop, pcsrc});
    end
  endtask

  task automatic test_lw();
    int exp_st[5] = '{0, 1, 2, 3, 4};
    op = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (state_o !== 4'(exp_st[i])) begin n_err++; $display("FAIL lw_state cyc%0d: got %0d exp %0d", i, state_o, exp_st[i]); end
      n_vec++;
      if (regwrite !== (exp_st[i] == 4)) begin n_err++; $display("FAIL lw_regwrite cyc%0d: got %b", i, regwrite); end
      if (exp_st[i] == 4) begin
        n_vec++;
        if ({memtoreg, regdst} !== 2'b10) begin n_err++; $display("FAIL lw_wb_sel: got %b exp 10", {memtoreg, regdst}); end
      end
      if (exp_st[i] == 3) begin
        n_vec++;
        if (iord !== 1'b1) begin n_err++; $display("FAIL lw_iord: got %b exp 1", iord); end
      end
      if (exp_st[i] == 1) begin
        n_vec++;
        if (alusrcb !== 2'b11) begin n_err++; $display("FAIL decode_alusrcb: got %b exp 11", alusrcb); end
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (state_o !== 4'd0) begin n_err++; $display("FAIL lw_end_state: got %0d exp 0", state_o); end
  endtask

  task automatic test_sw();
    int   exp_st[6] = '{0, 1, 2, 5, 5, 5};
    logic mr[6]     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    op = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i]; #1;
      n_vec++;
      if (state_o !== 4'(exp_st[i])) begin n_err++; $display("FAIL sw_state cyc%0d: got %0d exp %0d", i, state_o, exp_st[i]); end
      n_vec++;
      if (memwrite !== (exp_st[i] == 5)) begin n_err++; $display("FAIL sw_memwrite cyc%0d: got %b", i, memwrite); end
      n_vec++;
      if (regwrite !== 1'b0) begin n_err++; $display("FAIL sw_regwrite cyc%0d: got %b exp 0", i, regwrite); end
      if (exp_st[i] == 5) begin
        n_vec++;
        if (iord !== 1'b1) begin n_err++; $display("FAIL sw_iord cyc%0d: got %b exp 1", i, iord); end
      end
      if (exp_st[i] == 2) begin
        n_vec++;
        if ({alusrca, alusrcb} !== 3'b1_10) begin n_err++; $display("FAIL memadr_src: got %b exp 110", {alusrca, alusrcb}); end
      end
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    n_vec++;
    if (state_o !== 4'd0) begin n_err++; $display("FAIL sw_end_state: got %0d exp 0", state_o); end
  endtask

  task automatic test_back_to_back();
    int         exp_st[14] = '{0, 1, 6, 7, 0, 1, 9, 10, 0, 1, 11, 0, 1, 8};
    logic [5:0] ops[14]    = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h08, 6'h08, 6'h08,
                               6'h02, 6'h02, 6'h02, 6'h04, 6'h04, 6'h04};
    mem_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      op = ops[i]; #1;
      n_vec++;
      if (state_o !== 4'(exp_st[i])) begin n_err++; $display("FAIL b2b_state cyc%0d: got %0d exp %0d", i, state_o, exp_st[i]); end
      n_vec++;
      if (regwrite !== (exp_st[i] == 7 || exp_st[i] == 10)) begin n_err++; $display("FAIL b2b_regwrite cyc%0d: got %b", i, regwrite); end
      n_vec++;
      if (branch !== (exp_st[i] == 8)) begin n_err++; $display("FAIL b2b_branch cyc%0d: got %b", i, branch); end
      case (exp_st[i])
        6: begin
          n_vec++;
          if ({alusrca, alusrcb, aluop} !== 5'b1_00_10) begin n_err++; $display("FAIL rtype_ex: got %b exp 10010", {alusrca, alusrcb, aluop}); end
        end
        7: begin
          n_vec++;
          if ({regdst, memtoreg} !== 2'b10) begin n_err++; $display("FAIL aluwb_sel: got %b exp 10", {regdst, memtoreg}); end
        end
        9: begin
          n_vec++;
          if ({alusrca, alusrcb, aluop} !== 5'b1_10_00) begin n_err++; $display("FAIL addi_ex: got %b exp 11000", {alusrca, alusrcb, aluop}); end
        end
        10: begin
          n_vec++;
          if ({regdst, memtoreg} !== 2'b00) begin n_err++; $display("FAIL addiwb_sel: got %b exp 00", {regdst, memtoreg}); end
        end
        11: begin
          n_vec++;
          if ({pcsrc, pcwrite} !== 3'b10_1) begin n_err++; $display("FAIL jex: got %b exp 101", {pcsrc, pcwrite}); end
        end
        8: begin
          n_vec++;
          if ({pcsrc, aluop, alusrca, pcwrite} !== 6'b01_01_1_0) begin n_err++; $display("FAIL beqex: got %b exp 010110", {pcsrc, aluop, alusrca, pcwrite}); end
        end
        default: begin end
      endcase
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (state_o !== 4'd0) begin n_err++; $display("FAIL b2b_end_state: got %0d exp 0", state_o); end
  endtask

  task automatic test_fetch_stall();
    int   exp_st[7] = '{0, 0, 0, 0, 0, 1, 11};
    logic mr[7]     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op = 6'b000010;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      n_vec++;
      if (state_o !== 4'(exp_st[i])) begin n_err++; $display("FAIL stall_state cyc%0d: got %0d exp %0d", i, state_o, exp_st[i]); end
      if (exp_st[i] == 0) begin
        n_vec++;
        if ({pcwrite, irwrite} !== {mr[i], mr[i]}) begin n_err++; $display("FAIL stall_we cyc%0d: got %b exp %b%b", i, {pcwrite, irwrite}, mr[i], mr[i]); end
      end
      if (exp_st[i] == 11) begin
        n_vec++;
        if (pcwrite !== 1'b1) begin n_err++; $display("FAIL stall_jex_pcwrite: got %b exp 1", pcwrite); end
      end
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    n_vec++;
    if (state_o !== 4'd0) begin n_err++; $display("FAIL stall_end_state: got %0d exp 0", state_o); end
  endtask

  task automatic test_bne();
`ifdef MIPS_MC_BNE_EN
    int exp_st[3] = '{0, 1, 12};
    int n_cyc = 3;
`else
    int exp_st[3] = '{0, 1, 0};
    int n_cyc = 2;
`endif
    op = 6'b000101; mem_ready = 1'b1;
    for (int i = 0; i < n_cyc; i++) begin
      #1;
      n_vec++;
      if (state_o !== 4'(exp_st[i])) begin n_err++; $display("FAIL bne_state cyc%0d: got %0d exp %0d", i, state_o, exp_st[i]); end
      n_vec++;
      if (bne !== (exp_st[i] == 12)) begin n_err++; $display("FAIL bne_strobe cyc%0d: got %b", i, bne); end
`ifdef MIPS_MC_BNE_EN
      n_vec++;
      if (illegal_op !== 1'b0) begin n_err++; $display("FAIL bne_illegal cyc%0d: got %b exp 0", i, illegal_op); end
      if (exp_st[i] == 12) begin
        n_vec++;
        if ({pcsrc, aluop, alusrca} !== 5'b01_01_1) begin n_err++; $display("FAIL bneex: got %b exp 01011", {pcsrc, aluop, alusrca}); end
      end
`else
      n_vec++;
      if (illegal_op !== (exp_st[i] == 1)) begin n_err++; $display("FAIL bne_illegal cyc%0d: got %b", i, illegal_op); end
`endif
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (state_o !== 4'd0) begin n_err++; $display("FAIL bne_end_state: got %0d exp 0", state_o); end
  endtask

  task automatic test_illegal();
    op = 6'b111111; mem_ready = 1'b1;
    #1;
    n_vec++;
    if (illegal_op !== 1'b0) begin n_err++; $display("FAIL illegal_in_fetch: got %b exp 0", illegal_op); end
    @(negedge clk); #1;
    n_vec++;
    if ({state_o, illegal_op} !== 5'b0001_1) begin n_err++; $display("FAIL illegal_decode: got %b exp 00011", {state_o, illegal_op}); end
    @(negedge clk); #1;
    n_vec++;
    if ({state_o, illegal_op} !== 5'b0000_0) begin n_err++; $display("FAIL illegal_next: got %b exp 00000", {state_o, illegal_op}); end
  endtask

  task automatic test_reset_memrd();
    int   exp_st[4] = '{0, 1, 2, 3};
    logic mr[4]     = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i];
      rst_n     = (i != 3);
      #1;
      n_vec++;
      if (state_o !== 4'(exp_st[i])) begin n_err++; $display("FAIL rstrd_state cyc%0d: got %0d exp %0d", i, state_o, exp_st[i]); end
      n_vec++;
      if (regwrite !== 1'b0) begin n_err++; $display("FAIL rstrd_regwrite cyc%0d: got %b exp 0", i, regwrite); end
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    n_vec++;
    if ({state_o, regwrite, pcwrite} !== 6'b0000_0_0) begin n_err++; $display("FAIL rstrd_after: got %b exp 000000", {state_o, regwrite, pcwrite}); end
    rst_n = 1'b1; #1;
    n_vec++;
    if ({state_o, pcwrite, irwrite} !== 6'b0000_1_1) begin n_err++; $display("FAIL rstrd_release: got %b exp 000011", {state_o, pcwrite, irwrite}); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_fetch_stall();
    test_bne();
    test_illegal();
    test_reset_memrd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle MIPS control unit.
- Replaces the single-cycle main decoder once the core moves to a shared instruction/data memory and a single ALU reused across cycles.
- Sequences fetch, decode, execute, memory and writeback through a Moore FSM, with memory-ready handshakes.
- Drives the multi-cycle datapath muxes and write enables, plus aluop to the existing ALU decoder.

Parameters:
- STATE_W, 4, width of state register and debug state port.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- op  in  6  instr[31:26] from instruction register
- mem_ready  in  1  memory completes access this cycle
- pcwrite  out  1  unconditional PC write enable
- branch  out  1  PC write if ALU zero=1
- bne  out  1  PC write if ALU zero=0
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write request
- iord  out  1  memory address source: 0=PC, 1=ALUOut
- regwrite  out  1  register file write enable
- regdst  out  1  write register: 0=rt, 1=rd
- memtoreg  out  1  writeback data: 0=ALUOut, 1=data register
- alusrca  out  1  ALU operand A: 0=PC, 1=reg A
- alusrcb  out  2  ALU operand B: 00=reg B, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- aluop  out  2  to ALU decoder: 00=add, 01=sub, 10=funct
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported op
- state_o  out  STATE_W  current state (debug)

Behaviour:
- Clock and reset: single clock clk. rst_n sampled on clk: rst_n=0 forces state to FETCH at the next edge. While rst_n=0, all strobes (pcwrite, branch, bne, irwrite, memwrite, regwrite, illegal_op) are combinationally forced to 0. Reset mid-instruction abandons the instruction; no write strobe fires.
- Output timing: outputs are a function of state. Exception: in FETCH, pcwrite and irwrite = mem_ready. Mux selects not listed for a state are 0.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. Holds while mem_ready=0; mem_ready=1 -> DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - 000000 -> RTYPEEX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - other -> FETCH with illegal_op=1 for this cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. op=100011 -> MEMRD, else -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1, held every cycle until mem_ready=1, then -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- Unreachable state codes 13-15 -> FETCH next cycle, all strobes 0.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle adds 1 in FETCH, MEMRD or MEMWR.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Optional Feature:
- Macro MIPS_MC_BNE_EN.
- Defined: op=000101 in DECODE -> BNEEX. BNEEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, bne=1 -> FETCH (3 cycles).
- Undefined: op 000101 is illegal (illegal_op pulse, -> FETCH). bne is tied 0. State 12 is unreachable.
- The port list is identical in both builds.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - ALUSRCB_*, PCSRC_*, ALUOP_* encodings
- Sub-module mips_mc_outdec: pure combinational state -> control-word lookup. The top keeps the state register, next-state logic, mem_ready gating and reset masking.

Test Plan:
- Reset and hold: rst_n=0 for 3 cycles with mem_ready=1 -> state_o=0, all strobes 0. Release -> FETCH, pcwrite=irwrite=1.
- lw, mem_ready=1 throughout -> states 0,1,2,3,4,0. regwrite=1 only in state 4 with memtoreg=1, regdst=0.
- sw, mem_ready low 2 cycles in MEMWR -> memwrite=1, iord=1 for 3 consecutive cycles, then FETCH. regwrite never asserted.
- R-type then addi then j then beq back-to-back -> states 0,1,6,7 | 0,1,9,10 | 0,1,11 | 0,1,8. Check aluop=10 in state 6, pcsrc=10 with pcwrite in 11, branch=1 with pcsrc=01 in 8.
- FETCH stall: mem_ready=0 for 4 cycles -> state_o stays 0 with pcwrite=irwrite=0. First mem_ready=1 cycle asserts both; DECODE follows.
- op=000101, run once with and once without MIPS_MC_BNE_EN:
  - With macro -> states 0,1,12,0, bne=1 in 12.
  - Without macro -> illegal_op=1 in DECODE, next state 0, bne=0 always.
  - Also: rst_n=0 while in MEMRD -> FETCH next edge, no regwrite.
